// File: rtl/vga_textcon.sv
// rtl/vga_textcon.sv - VGA text console engine: cursor, control codes, scroll and clear sequences
// Optional newline scrolling at the last row is built when VGA_TEXTCON_SCROLL_EN is defined.
module vga_textcon (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic [12:0] vmem_addr,
    output logic [7:0]  vmem_dout,
    output logic        vmem_we,
    input  logic [7:0]  vmem_din,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);
    localparam logic [12:0] VMEMSTART = 13'd1024;
    localparam logic [12:0] ROW_STEP  = 13'd80;
    localparam logic [6:0]  LAST_COL  = 7'd79;
    localparam logic [5:0]  LAST_ROW  = 6'd59;
    localparam logic [7:0]  FILL      = 8'h20;
    localparam logic [12:0] LAST_CELL = VMEMSTART + 13'd4799;
`ifdef VGA_TEXTCON_SCROLL_EN
    localparam logic [12:0] SCR_FIRST = VMEMSTART + ROW_STEP;
    localparam logic [12:0] CLR_FIRST = VMEMSTART + 13'd4720;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_CLRLINE, S_CLRALL
    } state_t;

    state_t      state, next_state;
    logic [12:0] rowbase;
    logic [12:0] ptr;
    logic [7:0]  put_data;
    logic        put_adv;
    logic        accept, printable, line_end, newline, last_row;

    assign accept    = cmd_valid && (state == S_IDLE);
    assign printable = cmd_data[7:5] != 3'd0;
    assign last_row  = cursor_y == LAST_ROW;
    // A newline is either an explicit 0x0A or the implicit one after writing column 79.
    assign line_end  = (state == S_PUT) && put_adv && (cursor_x == LAST_COL);
    assign newline   = (accept && cmd_data == 8'h0A) || line_end;

`ifndef VGA_TEXTCON_SCROLL_EN
    logic unused_din;
    assign unused_din = ^vmem_din;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (cmd_valid) begin
                case (cmd_data)
`ifdef VGA_TEXTCON_SCROLL_EN
                    8'h0A:   if (last_row) next_state = S_SCR_RD;
`else
                    8'h0A:   next_state = S_IDLE;
`endif
                    8'h08:   if (cursor_x != 7'd0) next_state = S_PUT;
                    8'h0C:   next_state = S_CLRALL;
                    default: if (printable) next_state = S_PUT;
                endcase
            end
`ifdef VGA_TEXTCON_SCROLL_EN
            S_PUT:     next_state = (line_end && last_row) ? S_SCR_RD : S_IDLE;
            S_SCR_RD:  next_state = S_SCR_WR;
            S_SCR_WR:  next_state = (ptr == LAST_CELL) ? S_CLRLINE : S_SCR_RD;
            S_CLRLINE: if (ptr == LAST_CELL) next_state = S_IDLE;
`else
            S_PUT:     next_state = S_IDLE;
`endif
            S_CLRALL:  if (ptr == LAST_CELL) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        vmem_addr = 13'd0;
        vmem_dout = 8'd0;
        vmem_we   = 1'b0;
        case (state)
            S_PUT: begin
                vmem_addr = rowbase + {6'd0, cursor_x};
                vmem_dout = put_data;
                vmem_we   = 1'b1;
            end
            S_SCR_RD: vmem_addr = ptr;
            S_SCR_WR: begin
                vmem_addr = ptr - ROW_STEP;
                vmem_dout = vmem_din;
                vmem_we   = 1'b1;
            end
            S_CLRLINE, S_CLRALL: begin
                vmem_addr = ptr;
                vmem_dout = FILL;
                vmem_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // Cursor, row base and sequence pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cursor_x <= 7'd0;
            cursor_y <= 6'd0;
            rowbase  <= VMEMSTART;
            ptr      <= VMEMSTART;
            put_data <= 8'd0;
            put_adv  <= 1'b0;
        end else if (newline) begin
            cursor_x <= 7'd0;
            if (!last_row) begin
                cursor_y <= cursor_y + 6'd1;
                rowbase  <= rowbase + ROW_STEP;
            end else begin
`ifdef VGA_TEXTCON_SCROLL_EN
                ptr      <= SCR_FIRST;
`else
                cursor_y <= 6'd0;
                rowbase  <= VMEMSTART;
`endif
            end
        end else if (accept) begin
            case (cmd_data)
                8'h0D: cursor_x <= 7'd0;
                8'h08: if (cursor_x != 7'd0) begin
                    cursor_x <= cursor_x - 7'd1;
                    put_data <= FILL;
                    put_adv  <= 1'b0;
                end
                8'h0C: begin
                    cursor_x <= 7'd0;
                    cursor_y <= 6'd0;
                    rowbase  <= VMEMSTART;
                    ptr      <= VMEMSTART;
                end
                default: if (printable) begin
                    put_data <= cmd_data;
                    put_adv  <= 1'b1;
                end
            endcase
        end else if (state == S_PUT && put_adv) begin
            cursor_x <= cursor_x + 7'd1;
`ifdef VGA_TEXTCON_SCROLL_EN
        end else if (state == S_SCR_WR) begin
            ptr <= (ptr == LAST_CELL) ? CLR_FIRST : ptr + 13'd1;
        end else if (state == S_CLRLINE && ptr != LAST_CELL) begin
            ptr <= ptr + 13'd1;
`endif
        end else if (state == S_CLRALL && ptr != LAST_CELL) begin
            ptr <= ptr + 13'd1;
        end
    end
endmodule

// File: tb/tb_vga_textcon.sv
// tb/tb_vga_textcon.sv - self-checking bench for vga_textcon against a screen-level console model
module tb_vga_textcon;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic [12:0] vmem_addr;
    logic [7:0]  vmem_dout;
    logic        vmem_we;
    logic [7:0]  vmem_din;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;

    vga_textcon dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .vmem_addr(vmem_addr), .vmem_dout(vmem_dout),
        .vmem_we(vmem_we), .vmem_din(vmem_din), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Video memory with one-cycle read latency, plus a write monitor.
    logic [7:0]  mem [0:8191];
    int          wr_count = 0, bad_wr = 0, wr_min = 8191, wr_max = 0;
    int          last_wr_addr = -1;
    logic [7:0]  last_wr_data = 8'd0;
    always @(posedge clk) begin
        vmem_din <= mem[vmem_addr];
        if (vmem_we) begin
            mem[vmem_addr] <= vmem_dout;
            wr_count++;
            last_wr_addr = int'(vmem_addr);
            last_wr_data = vmem_dout;
            if (vmem_addr < 13'd1024 || vmem_addr > 13'd5823) bad_wr++;
            if (int'(vmem_addr) < wr_min) wr_min = int'(vmem_addr);
            if (int'(vmem_addr) > wr_max) wr_max = int'(vmem_addr);
        end
    end

    // Reference model: the 80x60 screen as a flat character array and a cursor.
    logic [7:0] scr [0:4799];
    int mx = 0, my = 0;
    int n_checks = 0, n_pass = 0;

    function automatic void model_newline();
        mx = 0;
        if (my < 59) my++;
        else begin
`ifdef VGA_TEXTCON_SCROLL_EN
            for (int i = 0; i < 4720; i++) scr[i] = scr[i + 80];
            for (int i = 4720; i < 4800; i++) scr[i] = 8'h20;
`else
            my = 0;
`endif
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h0A) model_newline();
        else if (b == 8'h0D) mx = 0;
        else if (b == 8'h08) begin
            if (mx > 0) begin mx--; scr[my * 80 + mx] = 8'h20; end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 4800; i++) scr[i] = 8'h20;
            mx = 0; my = 0;
        end else if (b >= 8'h20) begin
            scr[my * 80 + mx] = b;
            mx++;
            if (mx == 80) model_newline();
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, output int busy_cycles);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20000) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL send_ready_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_data = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        busy_cycles = 0;
        while (!cmd_ready && busy_cycles < 20000) begin @(negedge clk); busy_cycles++; end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL busy_timeout: busy for %0d cycles, required to end", busy_cycles);
        end
        model_byte(b);
    endtask

    task automatic check_screen(input string name);
        int bad = 0, first = -1;
        for (int i = 0; i < 4800; i++)
            if (mem[1024 + i] !== scr[i]) begin bad++; if (first < 0) first = i; end
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== (8'(i) ^ 8'h5A)) begin bad++; if (first < 0) first = i - 1024; end
        n_checks++;
        if (bad !== 0)
            $display("FAIL %s_screen: %0d wrong cells (first at cell %0d), required 0", name, bad, first);
        else n_pass++;
        n_checks++;
        if (cursor_x !== 7'(mx) || cursor_y !== 6'(my))
            $display("FAIL %s_cursor: got %0d,%0d required %0d,%0d", name, cursor_x, cursor_y, mx, my);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || vmem_we !== 1'b0 || vmem_addr !== 13'd0 ||
            vmem_dout !== 8'd0 || cursor_x !== 7'd0 || cursor_y !== 6'd0)
            $display("FAIL reset_state: ready=%0b busy=%0b we=%0b addr=%0d dout=%0h cur=%0d,%0d required 1 0 0 0 0 0,0",
                     cmd_ready, busy, vmem_we, vmem_addr, vmem_dout, cursor_x, cursor_y);
        else n_pass++;
    endtask

    task automatic test_put();
        int bc, w0;
        w0 = wr_count;
        send_byte(8'h41, bc);
        n_checks++;
        if (wr_count - w0 !== 1 || last_wr_addr !== 1024 || last_wr_data !== 8'h41)
            $display("FAIL put_write: %0d writes last %0d=%0h required 1 write 1024=41", wr_count - w0, last_wr_addr, last_wr_data);
        else n_pass++;
        n_checks++;
        if (bc !== 1) $display("FAIL put_busy: %0d cycles required 1", bc); else n_pass++;
        check_screen("put");
    endtask

    task automatic test_line_wrap();
        int bc, w0;
        send_byte(8'h0D, bc);
        w0 = wr_count; wr_min = 8191; wr_max = 0;
        for (int i = 0; i < 80; i++) send_byte(8'h30, bc);
        n_checks++;
        if (wr_count - w0 !== 80 || wr_min !== 1024 || wr_max !== 1103)
            $display("FAIL wrap_row: %0d writes span %0d..%0d required 80 span 1024..1103", wr_count - w0, wr_min, wr_max);
        else n_pass++;
        send_byte(8'h31, bc);
        n_checks++;
        if (last_wr_addr !== 1104 || last_wr_data !== 8'h31)
            $display("FAIL wrap_next: write %0d=%0h required 1104=31", last_wr_addr, last_wr_data);
        else n_pass++;
        check_screen("wrap");
    endtask

    task automatic test_clear();
        int bc, w0;
        send_byte(8'h5E, bc);
        w0 = wr_count; wr_min = 8191; wr_max = 0; bad_wr = 0;
        send_byte(8'h0C, bc);
        n_checks++;
        if (wr_count - w0 !== 4800 || wr_min !== 1024 || wr_max !== 5823 || bad_wr !== 0)
            $display("FAIL clear_writes: %0d writes span %0d..%0d bad %0d required 4800 span 1024..5823 bad 0",
                     wr_count - w0, wr_min, wr_max, bad_wr);
        else n_pass++;
        n_checks++;
        if (bc !== 4800) $display("FAIL clear_busy: %0d cycles required 4800", bc); else n_pass++;
        check_screen("clear");
    endtask

    task automatic test_backspace();
        int bc, w0;
        w0 = wr_count;
        send_byte(8'h08, bc);
        n_checks++;
        if (wr_count !== w0 || bc !== 0)
            $display("FAIL bs_origin: %0d writes %0d busy required 0 0", wr_count - w0, bc);
        else n_pass++;
        send_byte(8'h42, bc);
        send_byte(8'h08, bc);
        n_checks++;
        if (last_wr_addr !== 1024 || last_wr_data !== 8'h20)
            $display("FAIL bs_erase: write %0d=%0h required 1024=20", last_wr_addr, last_wr_data);
        else n_pass++;
        check_screen("bs");
    endtask

`ifdef VGA_TEXTCON_SCROLL_EN
    task automatic test_scroll();
        int bc;
        mem[1104] = 8'h55; scr[80] = 8'h55;
        mem[5823] = 8'h77; scr[4799] = 8'h77;
        for (int i = 0; i < 59; i++) send_byte(8'h0A, bc);
        bad_wr = 0;
        send_byte(8'h0A, bc);
        n_checks++;
        if (bc !== 9520) $display("FAIL scroll_busy: %0d cycles required 9520", bc); else n_pass++;
        n_checks++;
        if (mem[1024] !== 8'h55 || mem[5743] !== 8'h77 || mem[5744] !== 8'h20 || mem[5823] !== 8'h20 || bad_wr !== 0)
            $display("FAIL scroll_cells: 1024=%0h 5743=%0h 5744=%0h 5823=%0h bad=%0d required 55 77 20 20 0",
                     mem[1024], mem[5743], mem[5744], mem[5823], bad_wr);
        else n_pass++;
        check_screen("scroll");
    endtask
`else
    task automatic test_wrap_noscroll();
        int bc, w0;
        for (int i = 0; i < 59; i++) send_byte(8'h0A, bc);
        w0 = wr_count;
        send_byte(8'h0A, bc);
        n_checks++;
        if (wr_count !== w0 || cursor_x !== 7'd0 || cursor_y !== 6'd0)
            $display("FAIL noscroll_nl: %0d writes cursor %0d,%0d required 0 writes 0,0", wr_count - w0, cursor_x, cursor_y);
        else n_pass++;
        check_screen("noscroll");
    endtask
`endif

    task automatic test_random();
        int bc, r;
        logic [7:0] b;
        send_byte(8'h0C, bc);
        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 7) b = 8'h0A;
            else if (r < 11) b = 8'h0D;
            else if (r < 19) b = 8'h08;
            else if (r < 23) begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C) b = 8'h1B;
            end else b = 8'($urandom_range(32, 255));
            send_byte(b, bc);
            n_checks++;
            if (cursor_x !== 7'(mx) || cursor_y !== 6'(my))
                $display("FAIL rand_cursor[%0d] byte %0h: got %0d,%0d required %0d,%0d", k, b, cursor_x, cursor_y, mx, my);
            else n_pass++;
        end
        check_screen("rand");
    endtask

    task automatic test_reset_abort();
        int bc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 8'h0C;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || vmem_we !== 1'b0 || vmem_addr !== 13'd0 || cursor_x !== 7'd0 || cursor_y !== 6'd0)
            $display("FAIL abort_state: ready=%0b we=%0b addr=%0d cur=%0d,%0d required 1 0 0 0,0",
                     cmd_ready, vmem_we, vmem_addr, cursor_x, cursor_y);
        else n_pass++;
        rst = 1'b1;
        mx = 0; my = 0;
        send_byte(8'h0C, bc);
        send_byte(8'h7A, bc);
        check_screen("abort");
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = (i < 1024) ? (8'(i) ^ 8'h5A) : 8'h00;
        for (int i = 0; i < 4800; i++) scr[i] = 8'h00;
        rst = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_put();
        test_line_wrap();
        test_clear();
        test_backspace();
`ifdef VGA_TEXTCON_SCROLL_EN
        test_scroll();
`else
        test_wrap_noscroll();
`endif
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
